// File: rtl/audio_mix_i2s.sv
// audio_mix_i2s: mixes stereo BGM with the mono SFX sample, applies per-source
// volume (gain = vol/8), saturates to 16 bits and serializes the result as I2S.
// Compile-time option: SOFT_MUTE_EN replaces the hard mute with an 8-frame
// gain ramp (g = 0..8) applied after saturation.
module audio_mix_i2s #(
  parameter int SAMPLE_W = 16,
  parameter int VOL_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] bgm_l,
  input  logic [SAMPLE_W-1:0] bgm_r,
  input  logic [SAMPLE_W-1:0] sfx,
  input  logic [VOL_W-1:0]    bgm_vol,
  input  logic [VOL_W-1:0]    sfx_vol,
  input  logic                mute,
  output logic                sample_req,
  output logic                clip,
  output logic                audio_mclk,
  output logic                audio_sck,
  output logic                audio_lrck,
  output logic                audio_sdin
);

  // Product of a full-scale sample and the largest volume fits in this width.
  localparam int MIX_W = SAMPLE_W + VOL_W;
  localparam logic signed [MIX_W-1:0] SAT_MAX = MIX_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [MIX_W-1:0] SAT_MIN = -MIX_W'(2 ** (SAMPLE_W - 1));

  logic [8:0]          cnt;
  logic [SAMPLE_W-1:0] bgm_l_q, bgm_r_q, sfx_q;
  logic [VOL_W-1:0]    bgm_vol_q, sfx_vol_q;
  logic                mute_q;
  logic [SAMPLE_W-1:0] l_word, r_word;

  logic signed [MIX_W-1:0] mix_l, mix_r;
  logic [SAMPLE_W:0]       sat_l, sat_r;
  logic [SAMPLE_W-1:0]     out_l, out_r;
  logic                    clip_nxt;
  logic [4:0]              slot_nxt;
  logic [3:0]              bit_idx;
  logic                    use_l;
  logic                    sdin_nxt;

  wire frame_end = (cnt == 9'd511);
  wire mix_edge  = (cnt == 9'd0);
  wire bit_edge  = (cnt[3:0] == 4'hF);

  // (s * v) >>> 3 in MIX_W-bit signed arithmetic; volume is unsigned.
  function automatic logic signed [MIX_W-1:0] scale(input logic [SAMPLE_W-1:0] s,
                                                    input logic [VOL_W-1:0]    v);
    logic signed [MIX_W-1:0] s_ext, v_ext, prod;
    s_ext = {{VOL_W{s[SAMPLE_W-1]}}, s};
    v_ext = {{SAMPLE_W{1'b0}}, v};
    prod  = s_ext * v_ext;
    return prod >>> 3;
  endfunction

  // Returns {saturated_flag, clamped_value}.
  function automatic logic [SAMPLE_W:0] saturate(input logic signed [MIX_W-1:0] x);
    if (x > SAT_MAX)      return {1'b1, SAT_MAX[SAMPLE_W-1:0]};
    else if (x < SAT_MIN) return {1'b1, SAT_MIN[SAMPLE_W-1:0]};
    else                  return {1'b0, x[SAMPLE_W-1:0]};
  endfunction

`ifdef SOFT_MUTE_EN
  logic [3:0] gain, gain_nxt;
  logic [SAMPLE_W:0] gained_l, gained_r;

  // (s * g) >>> 3 with g in 0..8; the result never exceeds |s|.
  function automatic logic signed [MIX_W-1:0] apply_gain(input logic [SAMPLE_W-1:0] s,
                                                         input logic [3:0]          g);
    logic signed [MIX_W-1:0] s_ext, g_ext, prod;
    s_ext = {{VOL_W{s[SAMPLE_W-1]}}, s};
    g_ext = {{(MIX_W-4){1'b0}}, g};
    prod  = s_ext * g_ext;
    return prod >>> 3;
  endfunction

  // Gain steps once per frame toward 0 (muted) or 8 (unmuted); the new value
  // already applies to the frame being evaluated.
  always_comb begin
    gain_nxt = gain;
    if (mute_q && gain != 4'd0)        gain_nxt = gain - 4'd1;
    else if (!mute_q && gain != 4'd8)  gain_nxt = gain + 4'd1;
  end

  // Gain register, updated at each frame's mix evaluation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           gain <= 4'd8;
    else if (mix_edge) gain <= gain_nxt;
  end
`endif

  // Mix, saturation and mute handling for the latched frame inputs.
  always_comb begin
    mix_l = scale(bgm_l_q, bgm_vol_q) + scale(sfx_q, sfx_vol_q);
    mix_r = scale(bgm_r_q, bgm_vol_q) + scale(sfx_q, sfx_vol_q);
    sat_l = saturate(mix_l);
    sat_r = saturate(mix_r);
`ifdef SOFT_MUTE_EN
    gained_l = saturate(apply_gain(sat_l[SAMPLE_W-1:0], gain_nxt));
    gained_r = saturate(apply_gain(sat_r[SAMPLE_W-1:0], gain_nxt));
    out_l    = gained_l[SAMPLE_W-1:0];
    out_r    = gained_r[SAMPLE_W-1:0];
    clip_nxt = sat_l[SAMPLE_W] | sat_r[SAMPLE_W];
`else
    out_l    = sat_l[SAMPLE_W-1:0];
    out_r    = sat_r[SAMPLE_W-1:0];
    clip_nxt = sat_l[SAMPLE_W] | sat_r[SAMPLE_W];
    if (mute_q) begin
      out_l    = '0;
      out_r    = '0;
      clip_nxt = 1'b0;
    end
`endif
  end

  // Bit for the slot that begins on the next sck falling edge. Slots 1..16
  // carry L[15..0], slots 17..31 and 0 carry R[15..0]; at the frame wrap
  // r_word still holds the previous frame's right word.
  always_comb begin
    slot_nxt = cnt[8:4] + 5'd1;
    bit_idx  = 4'd0 - slot_nxt[3:0];
    use_l    = (slot_nxt != 5'd0) && (slot_nxt <= 5'd16);
    sdin_nxt = use_l ? l_word[bit_idx] : r_word[bit_idx];
  end

  // Frame counter, input latch, word registers and serial output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      bgm_l_q    <= '0;
      bgm_r_q    <= '0;
      sfx_q      <= '0;
      bgm_vol_q  <= '0;
      sfx_vol_q  <= '0;
      mute_q     <= 1'b0;
      sample_req <= 1'b0;
      l_word     <= '0;
      r_word     <= '0;
      clip       <= 1'b0;
      audio_sdin <= 1'b0;
    end else begin
      cnt        <= cnt + 9'd1;
      sample_req <= frame_end;
      if (frame_end) begin
        bgm_l_q   <= bgm_l;
        bgm_r_q   <= bgm_r;
        sfx_q     <= sfx;
        bgm_vol_q <= bgm_vol;
        sfx_vol_q <= sfx_vol;
        mute_q    <= mute;
      end
      if (mix_edge) begin
        l_word <= out_l;
        r_word <= out_r;
        clip   <= clip_nxt;
      end
      if (bit_edge) audio_sdin <= sdin_nxt;
    end
  end

  assign audio_mclk = cnt[1];
  assign audio_sck  = cnt[3];
  assign audio_lrck = cnt[8];

endmodule

// File: tb/tb_audio_mix_i2s.sv
// Directed bench for audio_mix_i2s: decodes the I2S stream and compares the
// recovered words against hand-computed mixes.
module tb_audio_mix_i2s;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bgm_l = '0, bgm_r = '0, sfx = '0;
  logic [3:0]  bgm_vol = '0, sfx_vol = '0;
  logic        mute = 1'b0;
  logic        sample_req, clip, audio_mclk, audio_sck, audio_lrck, audio_sdin;

  int passed = 0;
  int total  = 0;

  audio_mix_i2s dut (
    .clk        (clk),
    .rst        (rst),
    .bgm_l      (bgm_l),
    .bgm_r      (bgm_r),
    .sfx        (sfx),
    .bgm_vol    (bgm_vol),
    .sfx_vol    (sfx_vol),
    .mute       (mute),
    .sample_req (sample_req),
    .clip       (clip),
    .audio_mclk (audio_mclk),
    .audio_sck  (audio_sck),
    .audio_lrck (audio_lrck),
    .audio_sdin (audio_sdin)
  );

  always #5 clk = ~clk;

  // Captured frame results.
  logic        c_prev_r0;
  logic [15:0] c_l, c_r;
  logic        c_clip;
  int          c_unstable;
  logic [32:0] c_bits;

  task automatic apply(input logic [15:0] l, input logic [15:0] r, input logic [15:0] s,
                       input logic [3:0] bv, input logic [3:0] sv, input logic m);
    bgm_l = l; bgm_r = r; sfx = s; bgm_vol = bv; sfx_vol = sv; mute = m;
  endtask

  // Returns at the negedge inside the cycle where sample_req is high (cnt = 0).
  task automatic wait_req();
    bit got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (sample_req) got = 1'b1;
    end
    if (!got) begin
      total++;
      $display("FAIL wait_req: sample_req=0 after 600 cycles, required 1");
    end
  endtask

  // Waits for the next frame start and decodes its slots by sampling sdin
  // mid-slot (4 and 12 clk into the slot, either side of the sck rise).
  // With incl_next the R LSB is taken from the next frame's slot 0.
  task automatic capture(input int hook_at, input logic hook_mute, input logic [15:0] hook_bgm_l,
                         input bit incl_next);
    int last;
    wait_req();
    c_bits = '0;
    c_unstable = 0;
    c_clip = 1'b0;
    last = incl_next ? 524 : 508;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == hook_at) begin
        mute  = hook_mute;
        bgm_l = hook_bgm_l;
      end
      if (c == 4) c_clip = clip;
      if (c % 16 == 4) c_bits[c / 16] = audio_sdin;
      if (c % 16 == 12 && audio_sdin !== c_bits[c / 16]) c_unstable++;
    end
    c_prev_r0 = c_bits[0];
    for (int k = 1; k <= 15; k++) c_l[16 - k] = c_bits[k];
    c_l[0] = c_bits[16];
    for (int k = 17; k <= 31; k++) c_r[32 - k] = c_bits[k];
    c_r[0] = incl_next ? c_bits[32] : 1'b0;
  endtask

  task automatic test_reset();
    int first_req, req_cnt, m1, m2, s1, s2, l1, l2;
    logic pm, ps, pl;
    repeat (150) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req, clip} !== 6'b0) begin
      $display("FAIL reset_async: outputs=%b required 000000",
               {audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req, clip});
    end else passed++;
    repeat (3) @(negedge clk);
    total++;
    if ({audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req, clip} !== 6'b0) begin
      $display("FAIL reset_hold: outputs=%b required 000000",
               {audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req, clip});
    end else passed++;
    rst = 1'b0;
    first_req = -1; req_cnt = 0;
    m1 = -1; m2 = -1; s1 = -1; s2 = -1; l1 = -1; l2 = -1;
    pm = 1'b0; ps = 1'b0; pl = 1'b0;
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      if (sample_req) begin
        req_cnt++;
        if (first_req < 0) first_req = i;
      end
      if (audio_mclk && !pm) begin if (m1 < 0) m1 = i; else if (m2 < 0) m2 = i; end
      if (audio_sck  && !ps) begin if (s1 < 0) s1 = i; else if (s2 < 0) s2 = i; end
      if (audio_lrck && !pl) begin if (l1 < 0) l1 = i; else if (l2 < 0) l2 = i; end
      pm = audio_mclk; ps = audio_sck; pl = audio_lrck;
    end
    total++;
    if (first_req != 512) $display("FAIL first_sample_req: cycle %0d required 512", first_req);
    else passed++;
    total++;
    if (req_cnt != 1) $display("FAIL sample_req_pulses: count %0d required 1", req_cnt);
    else passed++;
    total++;
    if (m2 - m1 != 4 || m1 != 2) $display("FAIL mclk_period: rises %0d,%0d required 2,6", m1, m2);
    else passed++;
    total++;
    if (s2 - s1 != 16 || s1 != 8) $display("FAIL sck_period: rises %0d,%0d required 8,24", s1, s2);
    else passed++;
    total++;
    if (l2 - l1 != 512 || l1 != 256) $display("FAIL lrck_period: rises %0d,%0d required 256,768", l1, l2);
    else passed++;
  endtask

  task automatic test_nominal();
    wait_req();
    apply(16'h1000, 16'hF000, 16'h0800, 4'd8, 4'd8, 1'b0);
    capture(-1, 1'b0, 16'h1000, 1'b1);
    total++;
    if (c_l !== 16'h1800) $display("FAIL nominal_l: got %h required 1800", c_l); else passed++;
    total++;
    if (c_r !== 16'hF800) $display("FAIL nominal_r: got %h required f800", c_r); else passed++;
    total++;
    if (c_clip !== 1'b0) $display("FAIL nominal_clip: got %b required 0", c_clip); else passed++;
  endtask

  task automatic test_saturation();
    wait_req();
    apply(16'h7000, 16'h0000, 16'h7000, 4'd15, 4'd15, 1'b0);
    capture(-1, 1'b0, 16'h7000, 1'b1);
    total++;
    if (c_l !== 16'h7FFF) $display("FAIL sat_pos_l: got %h required 7fff", c_l); else passed++;
    total++;
    if (c_r !== 16'h7FFF) $display("FAIL sat_pos_r: got %h required 7fff", c_r); else passed++;
    total++;
    if (c_clip !== 1'b1) $display("FAIL sat_pos_clip: got %b required 1", c_clip); else passed++;
    wait_req();
    apply(16'h0000, 16'h8000, 16'h0000, 4'd15, 4'd15, 1'b0);
    capture(-1, 1'b0, 16'h0000, 1'b1);
    total++;
    if (c_l !== 16'h0000) $display("FAIL sat_neg_l: got %h required 0000", c_l); else passed++;
    total++;
    if (c_r !== 16'h8000) $display("FAIL sat_neg_r: got %h required 8000", c_r); else passed++;
    total++;
    if (c_clip !== 1'b1) $display("FAIL sat_neg_clip: got %b required 1", c_clip); else passed++;
  endtask

  task automatic test_rounding();
    wait_req();
    apply(16'hFFFF, 16'h0001, 16'h0000, 4'd1, 4'd0, 1'b0);
    capture(-1, 1'b0, 16'hFFFF, 1'b1);
    total++;
    if (c_l !== 16'hFFFF) $display("FAIL round_neg: got %h required ffff", c_l); else passed++;
    total++;
    if (c_r !== 16'h0000) $display("FAIL round_pos: got %h required 0000", c_r); else passed++;
    total++;
    if (c_clip !== 1'b0) $display("FAIL clip_clears: got %b required 0", c_clip); else passed++;
    wait_req();
    apply(16'h7FFF, 16'h8000, 16'h0000, 4'd8, 4'd8, 1'b0);
    capture(-1, 1'b0, 16'h7FFF, 1'b1);
    total++;
    if (c_l !== 16'h7FFF || c_r !== 16'h8000)
      $display("FAIL full_scale_unity: got %h/%h required 7fff/8000", c_l, c_r);
    else passed++;
    total++;
    if (c_clip !== 1'b0) $display("FAIL full_scale_no_clip: got %b required 0", c_clip); else passed++;
    wait_req();
    apply(16'h7FFF, 16'h8000, 16'h7FFF, 4'd0, 4'd0, 1'b0);
    capture(-1, 1'b0, 16'h7FFF, 1'b1);
    total++;
    if (c_l !== 16'h0000 || c_r !== 16'h0000)
      $display("FAIL vol_zero: got %h/%h required 0000/0000", c_l, c_r);
    else passed++;
  endtask

  task automatic test_alignment();
    wait_req();
    apply(16'hA5A5, 16'h0001, 16'h0000, 4'd8, 4'd0, 1'b0);
    wait_req();
    bgm_r = 16'h0002;
    capture(-1, 1'b0, 16'hA5A5, 1'b1);
    total++;
    if (c_prev_r0 !== 1'b1) $display("FAIL slot0_prev_r0: got %b required 1", c_prev_r0); else passed++;
    total++;
    if (c_bits[1] !== 1'b1 || c_bits[2] !== 1'b0)
      $display("FAIL slot1_2_msb: got %b%b required 10", c_bits[1], c_bits[2]);
    else passed++;
    total++;
    if (c_bits[16] !== 1'b1) $display("FAIL slot16_lsb: got %b required 1", c_bits[16]); else passed++;
    total++;
    if (c_l !== 16'hA5A5) $display("FAIL align_l: got %h required a5a5", c_l); else passed++;
    total++;
    if (c_r !== 16'h0002) $display("FAIL align_r: got %h required 0002", c_r); else passed++;
    total++;
    if (c_unstable != 0) $display("FAIL sdin_stable: unstable slots %0d required 0", c_unstable);
    else passed++;
  endtask

`ifdef SOFT_MUTE_EN
  task automatic test_mute();
    logic [15:0] exp_w;
    wait_req();
    apply(16'h4000, 16'h0000, 16'h0000, 4'd8, 4'd0, 1'b1);
    for (int f = 0; f < 8; f++) begin
      capture(-1, 1'b1, 16'h4000, 1'b0);
      exp_w = 16'h0800 * 16'(7 - f);
      total++;
      if (c_l !== exp_w) $display("FAIL soft_fade_down[%0d]: got %h required %h", f, c_l, exp_w);
      else passed++;
    end
    mute = 1'b0;
    for (int f = 0; f < 8; f++) begin
      capture(-1, 1'b0, 16'h4000, 1'b0);
      exp_w = 16'h0800 * 16'(f + 1);
      total++;
      if (c_l !== exp_w) $display("FAIL soft_fade_up[%0d]: got %h required %h", f, c_l, exp_w);
      else passed++;
    end
  endtask
`else
  task automatic test_mute();
    wait_req();
    apply(16'h1000, 16'hF000, 16'h0800, 4'd8, 4'd8, 1'b0);
    capture(200, 1'b1, 16'h1000, 1'b0);
    total++;
    if (c_l !== 16'h1800 || c_r !== 16'hF800)
      $display("FAIL mute_current_frame: got %h/%h required 1800/f800", c_l, c_r);
    else passed++;
    capture(-1, 1'b1, 16'h1000, 1'b1);
    total++;
    if (c_l !== 16'h0000 || c_r !== 16'h0000)
      $display("FAIL mute_next_frame: got %h/%h required 0000/0000", c_l, c_r);
    else passed++;
    mute = 1'b0;
    capture(-1, 1'b0, 16'h1000, 1'b1);
    total++;
    if (c_l !== 16'h1800 || c_r !== 16'hF800)
      $display("FAIL unmute: got %h/%h required 1800/f800", c_l, c_r);
    else passed++;
  endtask
`endif

  task automatic test_mid_frame_change();
    wait_req();
    apply(16'h1000, 16'h0000, 16'h0800, 4'd8, 4'd8, 1'b0);
    capture(100, 1'b0, 16'h2000, 1'b0);
    total++;
    if (c_l !== 16'h1800) $display("FAIL mid_frame_ignored: got %h required 1800", c_l); else passed++;
    capture(-1, 1'b0, 16'h2000, 1'b0);
    total++;
    if (c_l !== 16'h2800) $display("FAIL mid_frame_next: got %h required 2800", c_l); else passed++;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    test_nominal();
    test_saturation();
    test_reset();
    test_rounding();
    test_alignment();
    test_mute();
    test_mid_frame_change();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
